pwm_bank: RTL
=============

PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter N, default 8: counter, period and duty width in bits.
REQ-002 Parameter CHANNELS, default 4: number of independent PWM outputs.
REQ-003 Parameter PRESCALE, default 120: clk cycles per counter tick; 120 gives 10 us at 12 MHz; legal range 1 or more.
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 ena  in  1  high: prescaler and counter advance; low: both hold.
REQ-007 period  in  N  terminal count; sampled only when load=1.
REQ-008 duty  in  CHANNELS*N  per-channel compare value; channel i uses bits [i*N +: N]; sampled only when load=1.
REQ-009 mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled only when load=1.
REQ-010 load  in  1  single-cycle request to capture period, duty and mode into the shadow registers.
REQ-011 pwm_out  out  CHANNELS  registered PWM outputs.
REQ-012 sync  out  1  one-clk pulse, asserted the cycle after each period boundary.
REQ-013 pending  out  1  high while shadow values are not yet applied.

Function
REQ-014 Prescaler counts 0..PRESCALE-1 while ena=1 and wraps to 0. A tick fires on the cycle it holds PRESCALE-1. With PRESCALE=1, a tick fires every ena cycle.
REQ-015 Edge mode: on each tick, counter increments; on a tick with counter==period_a, it wraps to 0.
REQ-016 Center mode, on each tick:
- dir=up: counter increments; at period_a, dir flips to down.
- dir=down: counter decrements; at 0, dir flips to up.
- Each end value is held for exactly one tick.
REQ-017 Boundary = the tick that takes counter to 0:
- edge: from period_a;
- center: from 1 while dir=down;
- period_a==0: every tick.
REQ-018 On a boundary edge:
- active period, duty and mode take the shadow values if pending=1, then pending clears;
- dir is set to up.
REQ-019 A mode change at a boundary restarts the counter at 0, dir up; nothing else is disturbed.
REQ-020 Each clk, pwm_out[i] <= (counter < duty_a[i]): one-clk latency from counter to output.
- duty_a[i]==0 gives constant low.
- duty_a[i] > period_a (edge) gives constant high.
REQ-021 load=1 captures the inputs into the shadow and sets pending.
- A load while pending is already set overwrites the shadow; the last load wins.
REQ-022 A load on the same cycle as a boundary writes the shadow and keeps pending=1. That shadow applies at the next boundary, not the current one.
REQ-023 ena=0 freezes prescaler, counter, dir and pwm_out; load and pending still operate; no sync is produced.
REQ-024 Counter arithmetic is N-bit unsigned; the counter never exceeds period_a.

Reset
REQ-025 While rst=1, all state takes its reset value immediately and asynchronously:
- prescaler=0, counter=0, dir=up;
- period_a=2^N-1, duty_a=0, mode=edge;
- shadow registers=0;
- pending=0, sync=0, pwm_out=0.
REQ-026 Reset asserted mid-period discards any pending shadow. The first tick after release counts from 0.

Structure
REQ-027 The mode enum (PWM_EDGE, PWM_CENTER) and the direction enum (DIR_UP, DIR_DOWN) live in a shared package, pwm_pkg.
REQ-028 The prescaler is a single sub-module, pwm_prescaler (parameter PRESCALE; ports clk, rst, ena, tick). The compare logic is a generate loop over CHANNELS.

Verification
REQ-029 Edge mode, PRESCALE=1, load period=9 with duty=3,0,10,9 -> channel 0 high 3 of every 10 ticks; ch1 always low; ch2 always high; ch3 high 9/10; sync every 10 clk.
REQ-030 Center mode, period=4, duty=2 -> counter sequence 0,1,2,3,4,3,2,1 repeating; pwm_out[0] high 3 of 8 ticks; sync every 8 clk.
REQ-031 Load duty=5 mid-period, then load duty=7 before the boundary -> old duty holds until the boundary; the first new period uses 7; pending falls on the boundary edge.
REQ-032 Load asserted exactly on the boundary cycle -> the value applies one full period later; pending stays high through that period.
REQ-033 Toggle ena low for 5 clk mid-count, and assert rst mid-period with pending=1 -> ena low: counter and outputs frozen, no sync. rst: all outputs 0 immediately; after release, pending=0 and period_a=255.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types for the PWM bank.
//   pwm_mode_e - counting scheme: edge-aligned saw-tooth or center-aligned triangle
//   pwm_dir_e  - counter direction used by the center-aligned scheme
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides clk into counter ticks.
//   clk  in  sole clock
//   rst  in  asynchronous active-high reset
//   ena  in  high: prescaler advances; low: it holds
//   tick out combinational, high on the ena cycle the prescaler holds PRESCALE-1
module pwm_prescaler #(
  parameter int PRESCALE = 120
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  output logic tick
);

  // One bit minimum so PRESCALE=1 still has a legal (constant-zero) counter.
  localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] cnt;

  assign tick = ena && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (ena) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: CHANNELS PWM outputs sharing one prescaled counter.
//   clk      in  sole clock, rising edge
//   rst      in  asynchronous active-high reset
//   ena      in  high: prescaler/counter advance; low: counter, dir, pwm_out hold
//   period   in  N           terminal count, captured on load
//   duty     in  CHANNELS*N  compare values, channel i at [i*N +: N], captured on load
//   mode     in  0 edge-aligned, 1 center-aligned, captured on load
//   load     in  one-cycle capture request into the shadow registers
//   pwm_out  out CHANNELS    registered outputs, counter < duty
//   sync     out one-clk pulse the cycle after each period boundary
//   pending  out shadow captured but not yet applied
//
// Load protocol: load is a single-cycle request with no back-pressure. The
// cycle load is high, period/duty/mode are written into the shadow and
// pending rises. The shadow moves into the active set on the next period
// boundary; a load coinciding with a boundary lands after that transfer, so
// it waits for the following boundary and pending stays high.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int N        = 8,
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 120
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [N-1:0]          period,
  input  logic [CHANNELS*N-1:0] duty,
  input  logic                  mode,
  input  logic                  load,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic                  sync,
  output logic                  pending
);

  logic tick;

  pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .tick (tick)
  );

  // Active and shadow configuration.
  logic [N-1:0]          period_a, sh_period;
  logic [CHANNELS*N-1:0] duty_a,   sh_duty;
  pwm_mode_e             mode_a,   sh_mode;

  // Counter state: the value plus the direction the triangle is travelling.
  logic [N-1:0] counter, counter_nxt;
  pwm_dir_e     dir,     dir_nxt;
  logic         boundary;

  // Next counter / direction and the boundary flag (tick that lands on 0).
  always_comb begin
    counter_nxt = counter;
    dir_nxt     = dir;
    boundary    = 1'b0;
    if (tick) begin
      if (period_a == '0) begin
        // Degenerate one-value period: every tick is a boundary.
        boundary    = 1'b1;
        counter_nxt = '0;
      end else if (mode_a == PWM_EDGE) begin
        if (counter == period_a) begin
          boundary    = 1'b1;
          counter_nxt = '0;
        end else begin
          counter_nxt = counter + N'(1);
        end
      end else if (dir == DIR_UP) begin
        // Turn around as the top value is reached so it is held for one tick only.
        counter_nxt = counter + N'(1);
        if (counter_nxt == period_a) dir_nxt = DIR_DOWN;
      end else begin
        counter_nxt = counter - N'(1);
        if (counter == N'(1)) boundary = 1'b1;
      end
      if (boundary) dir_nxt = DIR_UP;
    end
  end

  // Per-channel compare against the current counter.
  logic [CHANNELS-1:0] pwm_cmp;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_cmp
    assign pwm_cmp[i] = counter < duty_a[i*N +: N];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
      dir     <= DIR_UP;
      sync    <= 1'b0;
    end else begin
      counter <= counter_nxt;
      dir     <= dir_nxt;
      sync    <= boundary;
    end
  end

  // Active set swaps only on a boundary; the counter is 0 then, so a mode or
  // period change restarts cleanly without extra logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_a <= '1;
      duty_a   <= '0;
      mode_a   <= PWM_EDGE;
    end else if (boundary && pending) begin
      period_a <= sh_period;
      duty_a   <= sh_duty;
      mode_a   <= sh_mode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_period <= '0;
      sh_duty   <= '0;
      sh_mode   <= PWM_EDGE;
      pending   <= 1'b0;
    end else if (load) begin
      sh_period <= period;
      sh_duty   <= duty;
      sh_mode   <= pwm_mode_e'(mode);
      pending   <= 1'b1;
    end else if (boundary) begin
      pending   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out <= '0;
    end else if (ena) begin
      pwm_out <= pwm_cmp;
    end
  end

endmodule
